pc_branch_unit: RTL and testbench

//  Program counter and branch-resolution stage, directly upstream of instruction fetch.

---
 rtl/pc_branch_unit_pkg.sv | 19 +
 rtl/pc_branch_unit_branch_resolve.sv | 53 +++++
 rtl/pc_branch_unit.sv | 109 ++++++++++
 tb/tb_pc_branch_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the PC / branch-resolution stage: branch opcodes and FSM state encoding.
package pc_branch_unit_pkg;

  localparam logic [2:0] kBEA = 3'b000;
  localparam logic [2:0] kBER = 3'b001;
  localparam logic [2:0] kBNA = 3'b010;
  localparam logic [2:0] kBNR = 3'b011;
  localparam logic [2:0] kBUN = 3'b100;

  // Opcodes above this value are undefined and reported through BadOp.
  localparam logic [2:0] kBR_LAST = kBUN;

  typedef enum logic [1:0] {IDLE, RUN, DONE} pc_state_t;

  function automatic logic is_valid_branch(input logic [2:0] op);
    return op <= kBR_LAST;
  endfunction

endpackage

// File: rtl/pc_branch_unit_branch_resolve.sv
// Combinational branch resolution: decides taken/not-taken and produces the resulting next PC.
module branch_resolve
  import pc_branch_unit_pkg::*;
#(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned OFF_W = 6
) (
  input  logic [2:0]       branch_op,
  input  logic             flag,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  target,
  input  logic [OFF_W-1:0] offset,
  output logic             taken,
  output logic [PC_W-1:0]  next_pc,
  output logic             bad_op
);

  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] rel_pc;
  logic [PC_W-1:0] seq_pc;
  logic            relative;

  // Sign-extend the offset to PC width; the add then wraps naturally modulo 2**PC_W.
  assign off_ext = PC_W'($signed(offset));
  assign rel_pc  = pc + off_ext;
  assign seq_pc  = pc + PC_W'(1);

  always_comb begin
    taken    = 1'b0;
    relative = 1'b0;
    bad_op   = !is_valid_branch(branch_op);
    case (branch_op)
      kBEA: taken = flag;
      kBNA: taken = !flag;
      kBUN: taken = 1'b1;
      kBER: begin
        taken    = flag;
        relative = 1'b1;
      end
      kBNR: begin
        taken    = !flag;
        relative = 1'b1;
      end
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = seq_pc;
    if (taken) next_pc = relative ? rel_pc : target;
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter and branch-resolution stage with Start/Done run control.
// Optional taken-branch counter enabled by defining BRANCH_STATS_EN.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int unsigned     PC_W       = 10,
  parameter int unsigned     OFF_W      = 6,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic [2:0]       BranchOp,
  input  logic [PC_W-1:0]  Target,
  input  logic [OFF_W-1:0] Offset,
  input  logic             FlagWrite,
  input  logic             FlagIn,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic             BadOp,
  output logic [15:0]      TakenCount
);

  pc_state_t       state, state_next;
  logic            flag;
  logic            start_run;
  logic            step;
  logic            br_valid;
  logic            res_taken;
  logic            res_bad;
  logic [PC_W-1:0] res_next_pc;
  logic [PC_W-1:0] pc_next;

  branch_resolve #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_resolve (
    .branch_op (BranchOp),
    .flag      (flag),
    .pc        (PC),
    .target    (Target),
    .offset    (Offset),
    .taken     (res_taken),
    .next_pc   (res_next_pc),
    .bad_op    (res_bad)
  );

  assign start_run = Start && (state == IDLE || state == DONE);
  // Halt wins over any branch issued in the same cycle.
  assign step      = (state == RUN) && !Halt;
  assign br_valid  = step && BranchEn;

  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (Halt)  state_next = DONE;
      DONE:    if (Start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Running = (state == RUN);
    Done    = (state == DONE);
  end

  always_comb begin
    pc_next = PC;
    if (start_run)                  pc_next = START_ADDR;
    else if (br_valid && res_taken) pc_next = res_next_pc;
    else if (step)                  pc_next = PC + PC_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      PC    <= '0;
      flag  <= 1'b0;
      BadOp <= 1'b0;
    end else begin
      PC    <= pc_next;
      BadOp <= br_valid && res_bad;
      if (start_run)                      flag <= 1'b0;
      else if (state == RUN && FlagWrite) flag <= FlagIn;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt;

  always_ff @(posedge Clk) begin
    if (!Reset_n || start_run)                  taken_cnt <= '0;
    else if (br_valid && res_taken && taken_cnt != '1) taken_cnt <= taken_cnt + 16'(1);
  end

  assign TakenCount = taken_cnt;
`else
  assign TakenCount = '0;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed self-checking bench for pc_branch_unit (PC_W=10, OFF_W=6, START_ADDR=0).
module tb_pc_branch_unit;
  import pc_branch_unit_pkg::*;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic        Halt;
  logic        BranchEn;
  logic [2:0]  BranchOp;
  logic [9:0]  Target;
  logic [5:0]  Offset;
  logic        FlagWrite;
  logic        FlagIn;
  logic [9:0]  PC;
  logic        Running;
  logic        Done;
  logic        BadOp;
  logic [15:0] TakenCount;

  int checks = 0;
  int errors = 0;

  pc_branch_unit #(
    .PC_W       (10),
    .OFF_W      (6),
    .START_ADDR (10'd0)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Halt       (Halt),
    .BranchEn   (BranchEn),
    .BranchOp   (BranchOp),
    .Target     (Target),
    .Offset     (Offset),
    .FlagWrite  (FlagWrite),
    .FlagIn     (FlagIn),
    .PC         (PC),
    .Running    (Running),
    .Done       (Done),
    .BadOp      (BadOp),
    .TakenCount (TakenCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef BRANCH_STATS_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  task automatic br(input logic [2:0] op, input logic [9:0] tgt, input logic [5:0] off);
    BranchEn = 1'b1;
    BranchOp = op;
    Target   = tgt;
    Offset   = off;
    tick();
    BranchEn = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0; Start = 1'b0; Halt = 1'b0; BranchEn = 1'b0; BranchOp = kBEA;
    Target = '0; Offset = '0; FlagWrite = 1'b0; FlagIn = 1'b0;
    tick(); tick();
    check("rst_pc", 32'(PC), 0);
    check("rst_running", 32'(Running), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_badop", 32'(BadOp), 0);
    check("rst_cnt", 32'(TakenCount), 0);

    // 1: reset mid-run
    Reset_n = 1'b1;
    Start = 1'b1; tick(); Start = 1'b0;
    check("t1_start_pc", 32'(PC), 0);
    check("t1_start_running", 32'(Running), 1);
    repeat (37) tick();
    check("t1_pc37", 32'(PC), 37);
    Reset_n = 1'b0; tick();
    check("t1_midrst_pc", 32'(PC), 0);
    check("t1_midrst_running", 32'(Running), 0);
    check("t1_midrst_done", 32'(Done), 0);
    Reset_n = 1'b1; tick(); tick();
    check("t1_idle_pc", 32'(PC), 0);
    check("t1_idle_running", 32'(Running), 0);
    Start = 1'b1; tick(); Start = 1'b0;
    check("t1_reload_pc", 32'(PC), 0);
    check("t1_reload_running", 32'(Running), 1);

    // 2: sequential run, Start ignored in RUN, halt and hold
    tick(); tick();
    check("t2_pc2", 32'(PC), 2);
    Start = 1'b1; tick(); Start = 1'b0;
    check("t2_start_ignored", 32'(PC), 3);
    tick(); tick();
    check("t2_pc5", 32'(PC), 5);
    Halt = 1'b1; tick(); Halt = 1'b0;
    check("t2_halt_pc", 32'(PC), 5);
    check("t2_halt_done", 32'(Done), 1);
    check("t2_halt_running", 32'(Running), 0);
    tick(); tick();
    check("t2_hold_pc", 32'(PC), 5);
    check("t2_hold_done", 32'(Done), 1);

    // 3: absolute branches
    Start = 1'b1; tick(); Start = 1'b0;
    check("t3_start_pc", 32'(PC), 0);
    check("t3_start_done", 32'(Done), 0);
    check("t3_start_cnt", 32'(TakenCount), 0);
    repeat (8) tick();
    check("t3_pc8", 32'(PC), 8);
    FlagWrite = 1'b1; FlagIn = 1'b1; tick(); FlagWrite = 1'b0;
    check("t3_pc9", 32'(PC), 9);
    br(kBEA, 10'd200, 6'd0);
    check("t3_bea_taken", 32'(PC), 200);
    br(kBNA, 10'd50, 6'd0);
    check("t3_bna_not", 32'(PC), 201);
    br(kBUN, 10'd3, 6'd0);
    check("t3_bun", 32'(PC), 3);

    // 4: relative branches and wrap
    br(kBUN, 10'd2, 6'd0);
    check("t4_pc2", 32'(PC), 2);
    br(kBER, 10'd500, 6'h3D);
    check("t4_ber_wrap", 32'(PC), 1023);
    tick();
    check("t4_seq_wrap", 32'(PC), 0);
    br(kBNR, 10'd500, 6'd5);
    check("t4_bnr_not", 32'(PC), 1);

    // 5: flag read-before-write, bad opcode
    FlagWrite = 1'b1; FlagIn = 1'b0;
    br(kBEA, 10'd100, 6'd0);
    FlagWrite = 1'b0;
    check("t5_bea_oldflag", 32'(PC), 100);
    br(kBEA, 10'd7, 6'd0);
    check("t5_bea_newflag", 32'(PC), 101);
    br(3'b110, 10'd400, 6'd9);
    check("t5_badop_pc", 32'(PC), 102);
    check("t5_badop_pulse", 32'(BadOp), 1);
    tick();
    check("t5_badop_clear", 32'(BadOp), 0);
    check("t5_pc103", 32'(PC), 103);
    br(kBNR, 10'd0, 6'd4);
    check("t5_bnr_taken", 32'(PC), 107);
    br(kBER, 10'd0, 6'd4);
    check("t5_ber_not", 32'(PC), 108);
    check("t5_cnt", 32'(TakenCount), exp_cnt(6));
    Halt = 1'b1;
    br(kBUN, 10'd500, 6'd0);
    Halt = 1'b0;
    check("t5_halt_over_branch", 32'(PC), 108);
    check("t5_halt_done", 32'(Done), 1);
    check("t5_halt_cnt", 32'(TakenCount), exp_cnt(6));

    // 6: taken-branch statistics
    Start = 1'b1; tick(); Start = 1'b0;
    check("t6_clear_cnt", 32'(TakenCount), 0);
    br(kBUN, 10'd10, 6'd0);
    br(kBEA, 10'd20, 6'd0);
    br(kBNA, 10'd30, 6'd0);
    br(kBER, 10'd0, 6'd1);
    br(kBNR, 10'd0, 6'h3F);
    check("t6_pc", 32'(PC), 30);
    check("t6_cnt3", 32'(TakenCount), exp_cnt(3));
    Halt = 1'b1; tick(); Halt = 1'b0;
    check("t6_done_cnt", 32'(TakenCount), exp_cnt(3));
    Start = 1'b1; tick(); Start = 1'b0;
    check("t6_restart_cnt", 32'(TakenCount), 0);
    check("t6_restart_pc", 32'(PC), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
